// File: rtl/cbd_seq.sv
// cbd_seq: buffers 16/24 PRF beats, runs the Kyber CBD sampler and streams 32 coefficient beats; CBD_SEQ_ABORT_EN adds i_abort
`timescale 1ns/1ps
module cbd (
  input  logic [1535:0] ibytes,
  input  logic [1:0]    eta,
  output logic [767:0]  coeffs
);
  for (genvar i = 0; i < 256; i++) begin : g_coef
    logic [3:0] n4;
    logic [5:0] n6;
    logic [2:0] a, b;
    assign n4 = ibytes[4*i +: 4];
    assign n6 = ibytes[6*i +: 6];
    assign a = (eta == 2'd3) ? 3'(n6[0]) + 3'(n6[1]) + 3'(n6[2]) : 3'(n4[0]) + 3'(n4[1]);
    assign b = (eta == 2'd3) ? 3'(n6[3]) + 3'(n6[4]) + 3'(n6[5]) : 3'(n4[2]) + 3'(n4[3]);
    assign coeffs[3*i +: 3] = a - b;
  end
endmodule

module cbd_seq #(
  parameter int BW_IN         = 64,
  parameter int COEF_PER_BEAT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_start,
  input  logic [1:0]                 i_eta,
  input  logic [BW_IN-1:0]           i_ibytes,
  input  logic                       i_ibytes_valid,
  output logic                       o_ibytes_ready,
  output logic [3*COEF_PER_BEAT-1:0] o_coeffs,
  output logic                       o_coeffs_valid,
  input  logic                       i_coeffs_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err
`ifdef CBD_SEQ_ABORT_EN
  ,
  input  logic                       i_abort
`endif
);
  localparam int OW = 3*COEF_PER_BEAT;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, EMIT = 2'd2;
  logic [1:0]    state;
  logic [1535:0] buffer;
  logic [4:0]    in_cnt, out_cnt;
  logic [1:0]    eta_q;
  logic [767:0]  all_coeffs;
  logic          abort;
  logic [4:0]    last_in;
`ifdef CBD_SEQ_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif
  cbd u_cbd (.ibytes(buffer), .eta(eta_q), .coeffs(all_coeffs));
  assign last_in        = eta_q[0] ? 5'd23 : 5'd15;
  assign o_ibytes_ready = state == LOAD;
  assign o_coeffs_valid = state == EMIT;
  assign o_busy         = state != IDLE;
  // buffer only changes in LOAD, so the muxed beat is stable under backpressure
  assign o_coeffs       = o_coeffs_valid ? all_coeffs[out_cnt*OW +: OW] : '0;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      buffer  <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      eta_q   <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (abort && state != IDLE) begin
        state   <= IDLE;
        buffer  <= '0;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else if (state == IDLE) begin
        if (i_start && i_eta[1]) begin
          eta_q   <= i_eta;
          buffer  <= '0;
          in_cnt  <= '0;
          out_cnt <= '0;
          state   <= LOAD;
        end else if (i_start) begin
          o_err <= 1'b1;
        end
      end else if (state == LOAD) begin
        if (i_ibytes_valid) begin
          buffer[in_cnt*BW_IN +: BW_IN] <= i_ibytes;
          in_cnt <= in_cnt + 5'd1;
          if (in_cnt == last_in) state <= EMIT;
        end
      end else if (i_coeffs_ready) begin
        if (out_cnt == 5'd31) begin
          state  <= IDLE;
          o_done <= 1'b1;
        end else begin
          out_cnt <= out_cnt + 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cbd_seq.sv
// tb_cbd_seq: directed and randomized checks of cbd_seq against a bit-stream CBD model
`timescale 1ns/1ps
module tb_cbd_seq;
  logic        i_clk = 0, i_rstn = 0, i_start = 0, i_ibytes_valid = 0, i_coeffs_ready = 0;
  logic [1:0]  i_eta = 0;
  logic [63:0] i_ibytes = 0;
  logic        o_ibytes_ready, o_coeffs_valid, o_busy, o_done, o_err;
  logic [23:0] o_coeffs;
`ifdef CBD_SEQ_ABORT_EN
  logic        i_abort = 0;
`endif
  int          checks = 0, errors = 0;
  logic [7:0]  mem [192];

  always #5 i_clk = ~i_clk;

  cbd_seq dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_eta(i_eta),
    .i_ibytes(i_ibytes), .i_ibytes_valid(i_ibytes_valid), .o_ibytes_ready(o_ibytes_ready),
    .o_coeffs(o_coeffs), .o_coeffs_valid(o_coeffs_valid), .i_coeffs_ready(i_coeffs_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef CBD_SEQ_ABORT_EN
    , .i_abort(i_abort)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: coefficient k consumes bits 2*eta*k.. of the little-endian byte stream
  function automatic int bitat(input int n);
    return int'(mem[n/8][n%8]);
  endfunction

  function automatic logic [23:0] ref_beat(input int eta, input int j);
    logic [23:0] r;
    int base, a, b;
    r = '0;
    for (int m = 0; m < 8; m++) begin
      base = 2*eta*(8*j+m);
      a = 0;
      b = 0;
      for (int t = 0; t < eta; t++) begin
        a += bitat(base+t);
        b += bitat(base+eta+t);
      end
      r[3*m +: 3] = 3'(a-b);
    end
    return r;
  endfunction

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < 192; i++) mem[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 192; i++) mem[i] = 8'($urandom);
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ready"}, 32'(o_ibytes_ready), 0);
    chk({tag, "_valid"}, 32'(o_coeffs_valid), 0);
    chk({tag, "_coeffs"}, 32'(o_coeffs), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  task automatic start(input logic [1:0] eta);
    chk("start_idle", 32'(o_busy), 0);
    i_start = 1;
    i_eta = eta;
    @(negedge i_clk);
    i_start = 0;
    i_eta = 2'($urandom);
    chk("start_busy", 32'(o_busy), 1);
    chk("start_ready", 32'(o_ibytes_ready), 1);
  endtask

  task automatic load(input int eta, input bit gaps, input int limit);
    int nb;
    nb = (eta == 3) ? 24 : 16;
    if (limit < nb) nb = limit;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        chk("gap_ready", 32'(o_ibytes_ready), 1);
        i_ibytes_valid = 0;
        i_start = 1;
        i_eta = 2'd1;
        @(negedge i_clk);
        i_start = 0;
        chk("ign_start_err", 32'(o_err), 0);
      end
      chk("load_ready", 32'(o_ibytes_ready), 1);
      i_ibytes_valid = 1;
      for (int k = 0; k < 8; k++) i_ibytes[8*k +: 8] = mem[8*b+k];
      @(negedge i_clk);
    end
    if (limit >= 24 || (eta == 2 && limit >= 16)) begin
      i_ibytes_valid = 0;
      chk("ready_drop", 32'(o_ibytes_ready), 0);
      chk("first_valid", 32'(o_coeffs_valid), 1);
    end
  endtask

  task automatic emit(input int eta, input int mode, input bit use_k, input logic [23:0] k, output int cycles);
    int beat, cyc;
    bit rdy;
    logic [23:0] e;
    beat = 0;
    cyc = 0;
    while (beat < 32 && cyc < 300) begin
      e = use_k ? k : ref_beat(eta, beat);
      chk("emit_valid", 32'(o_coeffs_valid), 1);
      chk("emit_coeffs", 32'(o_coeffs), 32'(e));
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      i_coeffs_ready = rdy;
      i_ibytes_valid = 1'($urandom_range(0, 1));
      @(negedge i_clk);
      cyc++;
      if (rdy) beat++;
    end
    i_coeffs_ready = 0;
    i_ibytes_valid = 0;
    cycles = cyc;
    chk("emit_bound", beat, 32);
    chk("done_pulse", 32'(o_done), 1);
    chk("end_valid", 32'(o_coeffs_valid), 0);
    chk("end_busy", 32'(o_busy), 0);
    chk("end_coeffs", 32'(o_coeffs), 0);
    @(negedge i_clk);
    chk("done_single", 32'(o_done), 0);
  endtask

  initial begin
    int cyc, eta;
    #3;
    outs_zero("reset");
    @(negedge i_clk);
    i_rstn = 1;
    @(negedge i_clk);
    outs_zero("post_reset");

    fill_const(8'h33);
    start(2'd2);
    load(2, 0, 99);
    emit(2, 0, 1, 24'h492492, cyc);

    fill_const(8'hCC);
    start(2'd2);
    load(2, 0, 99);
    emit(2, 1, 1, 24'hDB6DB6, cyc);
    chk("toggle_cycles", cyc, 64);

    for (int r = 0; r < 2; r++) begin
      fill_const(r == 0 ? 8'h00 : 8'hFF);
      start(2'd3);
      load(3, 0, 99);
      emit(3, 0, 1, 24'h000000, cyc);
    end

    for (int r = 0; r < 2; r++) begin
      i_start = 1;
      i_eta = (r == 0) ? 2'd1 : 2'd0;
      @(negedge i_clk);
      i_start = 0;
      chk("err_pulse", 32'(o_err), 1);
      chk("err_busy", 32'(o_busy), 0);
      chk("err_ready", 32'(o_ibytes_ready), 0);
      @(negedge i_clk);
      chk("err_single", 32'(o_err), 0);
      chk("err_busy2", 32'(o_busy), 0);
    end

    fill_rand();
    start(2'd3);
    load(3, 0, 10);
    #2 i_rstn = 0;
    #1 outs_zero("midrst");
    @(negedge i_clk);
    i_ibytes_valid = 0;
    i_rstn = 1;
    @(negedge i_clk);
    outs_zero("midrst_rel");
    fill_const(8'h33);
    start(2'd2);
    load(2, 0, 99);
    emit(2, 0, 1, 24'h492492, cyc);

    for (int r = 0; r < 6; r++) begin
      eta = (r % 2 == 0) ? 3 : 2;
      fill_rand();
      start(2'(eta));
      load(eta, 1, 99);
      emit(eta, 2, 0, 24'h0, cyc);
    end

`ifdef CBD_SEQ_ABORT_EN
    fill_const(8'h33);
    start(2'd2);
    load(2, 0, 99);
    for (int n = 0; n < 5; n++) begin
      chk("ab_coeffs", 32'(o_coeffs), 32'h492492);
      i_coeffs_ready = 1;
      @(negedge i_clk);
    end
    i_coeffs_ready = 0;
    i_abort = 1;
    @(negedge i_clk);
    i_abort = 0;
    chk("ab_valid", 32'(o_coeffs_valid), 0);
    chk("ab_done", 32'(o_done), 0);
    chk("ab_busy", 32'(o_busy), 0);
    fill_rand();
    start(2'd3);
    load(3, 0, 99);
    emit(3, 0, 0, 24'h0, cyc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
